// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding imem request at a time,
// buffers returned words in a small FIFO and hands {instr, pc+4} to decode with valid/ready.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4,
  input  logic        out_ready
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   FULL    = DEPTH[PW:0];

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  state_t              state_q, state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic [31:0]         addr_q, addr_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [PW:0]         count_q, count_d, count_pop;
  entry_t [DEPTH-1:0]  mem_q, mem_d;
  logic                ack, pop;
  logic [31:0]         target;

  assign ack    = req_q && imem_ack;
  assign pop    = valid_q && out_ready;
  assign target = redirect_pc & ~32'h3;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    head_d     = head_q;
    tail_d     = tail_q;
    mem_d      = mem_q;
    count_pop  = count_q - {{PW{1'b0}}, pop};
    count_d    = count_pop;
    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = target;
      // A request still in flight must complete before the new target can be asked for.
      if (req_q && !imem_ack) begin
        state_d = DISCARD;
      end else begin
        state_d = WAIT;
        req_d   = 1'b1;
        addr_d  = target;
      end
    end else begin
      if (pop) head_d = head_q + PTR_ONE;
      unique case (state_q)
        IDLE: begin
          if (count_pop < FULL) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        WAIT: begin
          if (ack) begin
            mem_d[tail_q].instr = imem_rdata;
            mem_d[tail_q].pc4   = addr_q + 32'd4;
            tail_d     = tail_q + PTR_ONE;
            count_d    = count_pop + CNT_ONE;
            fetch_pc_d = fetch_pc_q + 32'd4;
            // Keep fetching back-to-back only while the next word still has a slot.
            if (count_pop + CNT_ONE < FULL) begin
              addr_d = fetch_pc_q + 32'd4;
            end else begin
              req_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
        DISCARD: begin
          if (ack) begin
            state_d = WAIT;
            addr_d  = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign out_valid    = valid_q;
  assign out_instr    = valid_q ? mem_q[head_q].instr : 32'h0;
  assign out_pc_plus4 = valid_q ? mem_q[head_q].pc4   : 32'h0;
endmodule
